// File: rtl/e1_frame_checker.sv
// E1 receive framer: FAS/NFAS alignment, 30-channel demux and test-pattern check.
// Define E1_CHECKER_ERRCNT_EN to build the saturating mismatch counter.
module e1_frame_checker #(
    parameter int LOSS_THRESH = 3,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             locked,
    output logic [7:0]       ch_data,
    output logic [4:0]       ch_idx,
    output logic             ch_valid,
    output logic             mismatch,
    output logic             frame_done,
    output logic [ERR_W-1:0] frame_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        SEARCH,
        CONFIRM_NFAS,
        CONFIRM_FAS,
        LOCKED
    } state_t;

    localparam logic [2:0] THRESH = 3'(LOSS_THRESH);

    state_t     state;
    logic [4:0] ts;
    logic       odd;
    logic [2:0] miss;
    logic [2:0] miss_nxt;
    logic       is_fas;
    logic       is_nfas;
    logic       ts0;
    logic       mapped;
    logic       ts0_ok;
    logic [4:0] ch;
    logic [7:0] expected;

    assign is_fas   = din[6:0] == 7'h1B;
    assign is_nfas  = din[6];
    assign ts0      = ts == 5'd0;
    assign mapped   = (ts != 5'd0) && (ts != 5'd16);
    assign ch       = (ts <= 5'd15) ? ts - 5'd1 : ts - 5'd2;
    assign expected = (ch < 5'd15) ? 8'hE1 + {3'b000, ch}
                                   : 8'hF1 + {3'b000, ch - 5'd15};
    assign miss_nxt = miss + 3'd1;
    // odd holds the parity of the frame just finished; this TS0 opens the other one
    assign ts0_ok   = odd ? is_fas : is_nfas;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SEARCH;
            ts         <= 5'd0;
            odd        <= 1'b0;
            miss       <= 3'd0;
            locked     <= 1'b0;
            ch_data    <= 8'h00;
            ch_idx     <= 5'd0;
            ch_valid   <= 1'b0;
            mismatch   <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            ch_valid   <= 1'b0;
            mismatch   <= 1'b0;
            frame_done <= 1'b0;
            if (din_valid) begin
                ts <= ts + 5'd1;
                unique case (state)
                    SEARCH: begin
                        if (is_fas) begin
                            ts    <= 5'd1;
                            odd   <= 1'b0;
                            state <= CONFIRM_NFAS;
                        end
                    end
                    CONFIRM_NFAS: begin
                        if (ts0) begin
                            odd   <= ~odd;
                            state <= is_nfas ? CONFIRM_FAS : SEARCH;
                        end
                    end
                    CONFIRM_FAS: begin
                        if (ts0) begin
                            odd <= ~odd;
                            if (is_fas) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                miss   <= 3'd0;
                            end else begin
                                state <= SEARCH;
                            end
                        end
                    end
                    LOCKED: begin
                        if (ts0) begin
                            odd <= ~odd;
                            if (ts0_ok) begin
                                miss <= 3'd0;
                            end else if (miss_nxt == THRESH) begin
                                state  <= SEARCH;
                                locked <= 1'b0;
                                miss   <= 3'd0;
                            end else begin
                                miss <= miss_nxt;
                            end
                        end
                        if (mapped) begin
                            ch_valid <= 1'b1;
                            ch_idx   <= ch;
                            ch_data  <= din;
                            mismatch <= din != expected;
                        end
                        if (ts == 5'd31) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + ERR_W'(1);
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

`ifdef E1_CHECKER_ERRCNT_EN
    logic pay_err;

    // Counted on the accepting edge so err_cnt moves together with ch_valid
    assign pay_err = din_valid && (state == LOCKED) && mapped
                     && (din != expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (pay_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: doc/e1_frame_checker.md
# e1_frame_checker

Receive-side checker for the E1 test path. It accepts a byte-wide E1 stream of 32 timeslots per frame, acquires and holds frame alignment on the TS0 frame-alignment word, and demultiplexes the 30 payload timeslots (TS1–TS15, TS17–TS31) onto channel indices 0–29. It compares each payload byte against the fixed test pattern driven by the team's 30-channel pattern generator and reports mismatches and counts. It sits at the far end of the mux/SDH path, opposite the generator.

## Interface
- `LOSS_THRESH`, default 3: consecutive bad FAS words that drop lock (1–7).
- `ERR_W`, default 16: width of the error and frame counters.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `din` in 8: received timeslot byte, MSB first-transmitted bit.
- `din_valid` in 1: `din` carries one timeslot this cycle.
- `locked` out 1: frame alignment held.
- `ch_data` out 8: payload byte of the current channel.
- `ch_idx` out 5: channel index, 0–29.
- `ch_valid` out 1: one-cycle strobe; `ch_data` and `ch_idx` are valid.
- `mismatch` out 1: qualifies `ch_valid`; the byte differs from the expected pattern.
- `frame_done` out 1: one-cycle strobe after TS31 of a locked frame.
- `frame_cnt` out ERR_W: locked frames received, wrapping.
- `err_cnt` out ERR_W: payload mismatches, saturating.

## Operation
- Timeslot counter `ts` (5 bits) advances only on `din_valid` and wraps 31→0.
- FAS: `din[6:0]==7'h1B`; bit 7 (Si) is ignored. NFAS: `din[6]==1`.
- The frame parity bit toggles on each TS0 byte. Even frames expect FAS and odd frames expect NFAS.
- FSM states: SEARCH, CONFIRM_NFAS, CONFIRM_FAS, LOCKED.
  - SEARCH: each valid byte is tested for FAS. On a hit, set `ts`=1 and parity=even, then go to CONFIRM_NFAS.
  - CONFIRM_NFAS: at the next `ts`==0 byte, if it is NFAS go to CONFIRM_FAS, otherwise go to SEARCH.
  - CONFIRM_FAS: at the next `ts`==0 byte, if it is FAS go to LOCKED, otherwise go to SEARCH.
  - LOCKED: each even TS0 is checked for FAS and each odd TS0 for NFAS.
    - A failed check increments the miss counter. A passed check clears it.
    - When the miss counter reaches LOSS_THRESH, go to SEARCH, clear the miss counter and deassert `locked`.
- Re-search after loss restarts the FAS scan on the next valid byte. There is no sliding re-check of bytes already consumed.
- Channel mapping, applied only when LOCKED:
  - TS1–15 map to ch 0–14.
  - TS17–31 map to ch 15–29.
  - TS0 and TS16 produce no `ch_valid`.
- Expected pattern:
  - ch 0–14 expect 8'hE1+ch (E1..EF).
  - ch 15–29 expect 8'hF1+(ch−15) (F1..FF).
  - Compute with 8-bit arithmetic.
- `mismatch` = (`ch_data` != expected). `err_cnt` increments on `ch_valid`&&`mismatch` and saturates at all-ones.
- `frame_done` pulses and `frame_cnt` increments (wrapping) on the TS31 byte while LOCKED.

## Timing
- Reset values:
  - `locked`=0, `ch_valid`=0, `mismatch`=0, `frame_done`=0.
  - `ch_data`=0, `ch_idx`=0, `frame_cnt`=0, `err_cnt`=0.
  - FSM=SEARCH, `ts`=0, miss counter=0.
- Latency: `ch_valid`, `ch_data`, `ch_idx`, `mismatch` and `frame_done` are registered one cycle after the accepting `din_valid` edge.
- `locked` rises in the cycle after the confirming FAS byte is accepted. Payload output starts with TS1 of that frame.
- `locked` falls in the cycle after the LOSS_THRESH-th bad TS0. A payload byte in that same cycle cannot exist, because TS0 carries no payload.
- With `din_valid` low, all state holds and all strobes are 0. Gaps of any length are allowed.
- Reset mid-frame returns everything to reset values immediately. No partial-frame outputs follow.

## Configuration
- Macro `E1_CHECKER_ERRCNT_EN`.
  - Defined: `err_cnt` counts mismatches as above.
  - Undefined: `err_cnt` is constant 0 and the counter logic is removed.
  - `mismatch` is generated in both cases.

## Test plan
- Continuous valid stream of alternating FAS frame (TS0=8'h1B) and NFAS frame (TS0=8'h40), payload E1..EF/F1..FF in the mapped timeslots:
  - `locked`=1 after the third TS0.
  - 30 `ch_valid` per frame with `ch_idx` 0..29, `mismatch`=0.
  - `err_cnt`=0 and `frame_cnt` increments once per frame.
- Locked stream, TS5 of one frame corrupted to 8'h00 → a single `ch_valid` with `ch_idx`=4, `ch_data`=8'h00, `mismatch`=1; `err_cnt`=1 (0 if `E1_CHECKER_ERRCNT_EN` is undefined).
- Locked, then 2 bad FAS words with LOSS_THRESH=3 → stays locked. A third consecutive bad TS0 → `locked`=0 one cycle later and no further `ch_valid`.
- Start from `rst`, feed a random byte that happens to equal 8'h1B, followed by a bad NFAS → FSM returns to SEARCH and `locked` stays 0.
- Locked stream with `din_valid` toggled 1/0 every cycle → the same outputs as the continuous case, with strobes only after valid bytes.
- Assert `rst` at TS20 while locked → all outputs 0 next cycle. Re-acquisition needs 3 TS0 words again.
